// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, function codes, result-group selects and scheduler FSM states.
// Result group is always fun[3:2]; fun[1:0] picks the operation inside the group.
package alu_pkg;

  localparam int DEF_OPERAND_SIZE = 16;
  localparam int DEF_ALU_OUT      = 32;

  localparam logic [3:0] FUN_ADD   = 4'b0000;
  localparam logic [3:0] FUN_SUB   = 4'b0001;
  localparam logic [3:0] FUN_MUL   = 4'b0010;
  localparam logic [3:0] FUN_DIV   = 4'b0011;
  localparam logic [3:0] FUN_AND   = 4'b0100;
  localparam logic [3:0] FUN_OR    = 4'b0101;
  localparam logic [3:0] FUN_NAND  = 4'b0110;
  localparam logic [3:0] FUN_NOR   = 4'b0111;
  localparam logic [3:0] FUN_NOP   = 4'b1000;
  localparam logic [3:0] FUN_CMPEQ = 4'b1001;
  localparam logic [3:0] FUN_CMPGT = 4'b1010;
  localparam logic [3:0] FUN_CMPLT = 4'b1011;
  localparam logic [3:0] FUN_SHR_A = 4'b1100;
  localparam logic [3:0] FUN_SHL_A = 4'b1101;
  localparam logic [3:0] FUN_SHR_B = 4'b1110;
  localparam logic [3:0] FUN_SHL_B = 4'b1111;

  localparam logic [1:0] GRP_ARITH = 2'b00;
  localparam logic [1:0] GRP_LOGIC = 2'b01;
  localparam logic [1:0] GRP_CMP   = 2'b10;
  localparam logic [1:0] GRP_SHIFT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } sched_state_t;

  function automatic logic [1:0] fun_group(input logic [3:0] fun);
    return fun[3:2];
  endfunction

endpackage

// File: rtl/alu_op_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant, last_grant updated on i_update.
// Zero latency; a lone valid is granted directly, contention goes to the side opposite last_grant.
import alu_pkg::*;

module rr_arbiter2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_valid,
  input  logic       i_update,
  output logic [1:0] o_grant
);

  logic r_last_grant;

  always_comb begin
    o_grant = 2'b00;
    case (i_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = r_last_grant ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

  // Reset value 1 makes req0 the winner of the first contention.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_grant <= 1'b1;
    end else if (i_update) begin
      r_last_grant <= o_grant[1];
    end
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// Shares one ALU between two requesters; ALU_LAT+2 cycles per op, response held until rsp_ready.
// Optional ALU_SCHED_DIVZERO_EN: DIV by zero skips the ALU and answers with rsp_err next cycle.
import alu_pkg::*;

module alu_op_scheduler #(
  parameter int OPERAND_SIZE = DEF_OPERAND_SIZE,
  parameter int ALU_OUT      = DEF_ALU_OUT,
  parameter int ALU_LAT      = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_req0_valid,
  output logic                    o_req0_ready,
  input  logic [OPERAND_SIZE-1:0] i_req0_a,
  input  logic [OPERAND_SIZE-1:0] i_req0_b,
  input  logic [3:0]              i_req0_fun,
  input  logic                    i_req1_valid,
  output logic                    o_req1_ready,
  input  logic [OPERAND_SIZE-1:0] i_req1_a,
  input  logic [OPERAND_SIZE-1:0] i_req1_b,
  input  logic [3:0]              i_req1_fun,
  output logic [OPERAND_SIZE-1:0] o_alu_a,
  output logic [OPERAND_SIZE-1:0] o_alu_b,
  output logic [3:0]              o_alu_fun,
  input  logic [ALU_OUT-1:0]      i_arith_out,
  input  logic [ALU_OUT-1:0]      i_logic_out,
  input  logic [ALU_OUT-1:0]      i_cmp_out,
  input  logic [ALU_OUT-1:0]      i_shift_out,
  input  logic                    i_arith_flag,
  input  logic                    i_carry_out,
  input  logic                    i_logic_flag,
  input  logic                    i_cmp_flag,
  input  logic                    i_shift_flag,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic                    o_rsp_id,
  output logic [ALU_OUT-1:0]      o_rsp_data,
  output logic                    o_rsp_carry,
  output logic                    o_rsp_err,
  output logic                    o_busy
);

  localparam logic [2:0] LAT_M1 = 3'(ALU_LAT - 1);

  sched_state_t            r_state;
  logic [2:0]              r_cnt;
  logic [OPERAND_SIZE-1:0] r_alu_a;
  logic [OPERAND_SIZE-1:0] r_alu_b;
  logic [3:0]              r_alu_fun;
  logic                    r_rsp_valid;
  logic                    r_rsp_id;
  logic [ALU_OUT-1:0]      r_rsp_data;
  logic                    r_rsp_carry;
  logic                    r_rsp_err;
  logic                    r_busy;

  logic [1:0]              w_grant;
  logic                    w_idle;
  logic                    w_accept;
  logic [OPERAND_SIZE-1:0] w_a;
  logic [OPERAND_SIZE-1:0] w_b;
  logic [3:0]              w_fun;
  logic                    w_divzero;
  logic [ALU_OUT-1:0]      w_sel;
  logic                    w_unused_flags;

  assign w_unused_flags = ^{i_arith_flag, i_logic_flag, i_cmp_flag, i_shift_flag};

  assign w_idle       = (r_state == ST_IDLE);
  assign w_accept     = w_idle && (w_grant != 2'b00);
  assign o_req0_ready = w_idle && w_grant[0];
  assign o_req1_ready = w_idle && w_grant[1];

  rr_arbiter2 u_arb (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  ({i_req1_valid, i_req0_valid}),
    .i_update (w_accept),
    .o_grant  (w_grant)
  );

  assign w_a   = w_grant[1] ? i_req1_a   : i_req0_a;
  assign w_b   = w_grant[1] ? i_req1_b   : i_req0_b;
  assign w_fun = w_grant[1] ? i_req1_fun : i_req0_fun;

`ifdef ALU_SCHED_DIVZERO_EN
  assign w_divzero = (w_fun == FUN_DIV) && (w_b == '0);
`else
  assign w_divzero = 1'b0;
`endif

  always_comb begin
    w_sel = i_arith_out;
    case (fun_group(r_alu_fun))
      GRP_LOGIC: w_sel = i_logic_out;
      GRP_CMP:   w_sel = i_cmp_out;
      GRP_SHIFT: w_sel = i_shift_out;
      default:   w_sel = i_arith_out;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 3'd0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_fun   <= 4'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_carry <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_rsp_id <= w_grant[1];
            r_busy   <= 1'b1;
            if (w_divzero) begin
              // ALU operands stay untouched; the error answer is formed here.
              r_rsp_data  <= '0;
              r_rsp_carry <= 1'b0;
              r_rsp_err   <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_state     <= ST_RESP;
            end else begin
              r_alu_a   <= w_a;
              r_alu_b   <= w_b;
              r_alu_fun <= w_fun;
              r_cnt     <= LAT_M1;
              r_state   <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == 3'd0) begin
            r_rsp_data  <= w_sel;
            r_rsp_carry <= (fun_group(r_alu_fun) == GRP_ARITH) && i_carry_out;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_alu_a     = r_alu_a;
  assign o_alu_b     = r_alu_b;
  assign o_alu_fun   = r_alu_fun;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_carry = r_rsp_carry;
  assign o_rsp_err   = r_rsp_err;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed bench for alu_op_scheduler with a behavioural single-cycle ALU on the ALU side.
module tb_alu_op_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]  req0_fun = '0, req1_fun = '0;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_fun;
  logic [31:0] arith_out, logic_out, cmp_out, shift_out;
  logic        carry_out;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_carry, rsp_err, busy;
  logic [31:0] rsp_data;
  logic [35:0] rsp_vec;
  logic [3:0]  ctl_vec;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] sweep_exp [16] = '{32'd136, 32'd120, 32'd1024, 32'd16, 32'd0, 32'd136,
                                  32'hFFFFFFFF, 32'hFFFFFF77, 32'd0, 32'd0, 32'd2, 32'd0,
                                  32'd64, 32'd256, 32'd4, 32'd16};

  always #5 clk = ~clk;

  assign rsp_vec = {rsp_valid, rsp_id, rsp_carry, rsp_err, rsp_data};
  assign ctl_vec = {req1_ready, req0_ready, rsp_valid, busy};

  // ALU stand-in: every group computes its own result so a wrong group select is visible.
  logic [31:0] ea, eb;
  logic [16:0] sum17;
  always_comb begin
    ea = {16'h0, alu_a};
    eb = {16'h0, alu_b};
    sum17 = {1'b0, alu_a} + {1'b0, alu_b};
    carry_out = sum17[16];
    arith_out = 32'd0;
    logic_out = 32'd0;
    cmp_out   = 32'd0;
    shift_out = 32'd0;
    case (alu_fun[1:0])
      2'd0: begin arith_out = ea + eb; logic_out = ea & eb;    cmp_out = 32'd0;                  shift_out = ea >> 1; end
      2'd1: begin arith_out = ea - eb; logic_out = ea | eb;    cmp_out = (ea == eb) ? 32'd1 : 0; shift_out = ea << 1; end
      2'd2: begin arith_out = ea * eb; logic_out = ~(ea & eb); cmp_out = (ea > eb) ? 32'd2 : 0;  shift_out = eb >> 1; end
      default: begin
        arith_out = (eb == 0) ? 32'hFFFFFFFF : ea / eb;
        logic_out = ~(ea | eb);
        cmp_out   = (ea < eb) ? 32'd3 : 0;
        shift_out = eb << 1;
      end
    endcase
  end

  alu_op_scheduler dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(req0_valid), .o_req0_ready(req0_ready),
    .i_req0_a(req0_a), .i_req0_b(req0_b), .i_req0_fun(req0_fun),
    .i_req1_valid(req1_valid), .o_req1_ready(req1_ready),
    .i_req1_a(req1_a), .i_req1_b(req1_b), .i_req1_fun(req1_fun),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_fun(alu_fun),
    .i_arith_out(arith_out), .i_logic_out(logic_out), .i_cmp_out(cmp_out), .i_shift_out(shift_out),
    .i_arith_flag(1'b0), .i_carry_out(carry_out), .i_logic_flag(1'b0), .i_cmp_flag(1'b0),
    .i_shift_flag(1'b0),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id), .o_rsp_data(rsp_data),
    .o_rsp_carry(rsp_carry), .o_rsp_err(rsp_err), .o_busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [72:0] got;
    rst_n = 1'b0;
    step(); step();
    got = {alu_a, alu_b, alu_fun, rsp_vec, req1_ready, req0_ready, busy};
    n_checks++;
    if (got !== 73'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", got);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_contention();
    logic [35:0] exp_rsp;
    logic        exp_id;
    rsp_ready = 1'b1;
    req0_a = 16'd128; req0_b = 16'd8; req0_fun = 4'b0010;
    req1_a = 16'd128; req1_b = 16'd8; req1_fun = 4'b1010;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_id = k[0];
      #1;
      n_checks++;
      if (ctl_vec !== (exp_id ? 4'b1000 : 4'b0100)) begin
        n_fail++;
        $display("FAIL contention_grant[%0d]: got %b want %b", k, ctl_vec, exp_id ? 4'b1000 : 4'b0100);
      end
      step();
      n_checks++;
      if (ctl_vec !== 4'b0001) begin
        n_fail++;
        $display("FAIL contention_wait[%0d]: got %b want 0001", k, ctl_vec);
      end
      step();
      exp_rsp = {1'b1, exp_id, 1'b0, 1'b0, exp_id ? 32'd2 : 32'd1024};
      n_checks++;
      if (rsp_vec !== exp_rsp) begin
        n_fail++;
        $display("FAIL contention_rsp[%0d]: got %h want %h", k, rsp_vec, exp_rsp);
      end
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_single();
    rsp_ready = 1'b1;
    req0_a = 16'd128; req0_b = 16'd8; req0_fun = 4'b0000; req0_valid = 1'b1;
    #1;
    n_checks++;
    if (ctl_vec !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_ready: got %b want 0100", ctl_vec);
    end
    step();
    req0_valid = 1'b0;
    #1;
    n_checks++;
    if ({ctl_vec, alu_a, alu_b, alu_fun} !== {4'b0001, 16'd128, 16'd8, 4'b0000}) begin
      n_fail++;
      $display("FAIL single_issue: got %b %h %h %h want 0001 0080 0008 0", ctl_vec, alu_a, alu_b, alu_fun);
    end
    step();
    n_checks++;
    if (rsp_vec !== {4'b1000, 32'd136}) begin
      n_fail++;
      $display("FAIL single_rsp: got %h want %h", rsp_vec, {4'b1000, 32'd136});
    end
    step();
    n_checks++;
    if (ctl_vec !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_idle: got %b want 0000", ctl_vec);
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    req1_a = 16'd128; req1_b = 16'd8; req1_fun = 4'b1100; req1_valid = 1'b1;
    #1;
    n_checks++;
    if (ctl_vec !== 4'b1000) begin
      n_fail++;
      $display("FAIL bp_grant: got %b want 1000", ctl_vec);
    end
    step();
    req1_valid = 1'b0;
    req0_a = 16'd1000; req0_b = 16'd8; req0_fun = 4'b0000; req0_valid = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (rsp_vec !== {4'b1100, 32'd64}) begin
        n_fail++;
        $display("FAIL bp_hold_rsp[%0d]: got %h want %h", i, rsp_vec, {4'b1100, 32'd64});
      end
      n_checks++;
      if (ctl_vec !== 4'b0011) begin
        n_fail++;
        $display("FAIL bp_no_ready[%0d]: got %b want 0011", i, ctl_vec);
      end
      req0_a = 16'(1001 + i);
      step();
    end
    req0_a = 16'd128;
    rsp_ready = 1'b1;
    #1;
    n_checks++;
    if (ctl_vec !== 4'b0011) begin
      n_fail++;
      $display("FAIL bp_release: got %b want 0011", ctl_vec);
    end
    step();
    n_checks++;
    if (ctl_vec !== 4'b0100) begin
      n_fail++;
      $display("FAIL bp_idle: got %b want 0100", ctl_vec);
    end
    step();
    req0_valid = 1'b0;
    step();
    n_checks++;
    if (rsp_vec !== {4'b1000, 32'd136}) begin
      n_fail++;
      $display("FAIL bp_late_sample: got %h want %h", rsp_vec, {4'b1000, 32'd136});
    end
    step();
  endtask

  task automatic test_sweep();
    logic [39:0] exp_v;
    rsp_ready = 1'b1;
    req0_a = 16'd128; req0_b = 16'd8;
    for (int f = 0; f < 16; f++) begin
      req0_fun = 4'(f);
      req0_valid = 1'b1;
      step();
      req0_valid = 1'b0;
      step();
      exp_v = {4'(f), 4'b1000, sweep_exp[f]};
      n_checks++;
      if ({alu_fun, rsp_vec} !== exp_v) begin
        n_fail++;
        $display("FAIL sweep_fun%0d: got %h want %h", f, {alu_fun, rsp_vec}, exp_v);
      end
      step();
    end
  endtask

  task automatic test_carry();
    rsp_ready = 1'b1;
    req1_a = 16'hFFFF; req1_b = 16'd1; req1_fun = 4'b0000; req1_valid = 1'b1;
    step();
    req1_valid = 1'b0;
    step();
    n_checks++;
    if (rsp_vec !== {4'b1110, 32'h00010000}) begin
      n_fail++;
      $display("FAIL carry_add: got %h want %h", rsp_vec, {4'b1110, 32'h00010000});
    end
    step();
    req1_fun = 4'b0100; req1_valid = 1'b1;
    step();
    req1_valid = 1'b0;
    step();
    n_checks++;
    if (rsp_vec !== {4'b1100, 32'd1}) begin
      n_fail++;
      $display("FAIL carry_gated: got %h want %h", rsp_vec, {4'b1100, 32'd1});
    end
    step();
  endtask

  task automatic test_reset_midop();
    logic [68:0] got;
    rsp_ready = 1'b1;
    req1_a = 16'd128; req1_b = 16'd8; req1_fun = 4'b0000; req1_valid = 1'b1;
    step();
    req1_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    got = {alu_a, alu_b, alu_fun, rsp_vec, busy};
    n_checks++;
    if (got !== 69'd0) begin
      n_fail++;
      $display("FAIL midop_reset: got %h want 0", got);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({rsp_valid, busy} !== 2'b00) begin
        n_fail++;
        $display("FAIL midop_no_rsp[%0d]: got %b want 00", i, {rsp_valid, busy});
      end
    end
    req0_a = 16'd128; req0_b = 16'd8; req0_fun = 4'b0001; req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    n_checks++;
    if (ctl_vec !== 4'b0100) begin
      n_fail++;
      $display("FAIL midop_rr_reset: got %b want 0100", ctl_vec);
    end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    n_checks++;
    if (rsp_vec !== {4'b1000, 32'd120}) begin
      n_fail++;
      $display("FAIL midop_next: got %h want %h", rsp_vec, {4'b1000, 32'd120});
    end
    step();
  endtask

  task automatic test_divzero();
    rsp_ready = 1'b1;
    req0_a = 16'd128; req0_b = 16'd0; req0_fun = 4'b0011; req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
`ifdef ALU_SCHED_DIVZERO_EN
    n_checks++;
    if ({busy, rsp_valid, alu_fun, alu_b} !== {2'b11, 4'b0001, 16'd8}) begin
      n_fail++;
      $display("FAIL divzero_skip_alu: got %h want %h", {busy, rsp_valid, alu_fun, alu_b}, {2'b11, 4'b0001, 16'd8});
    end
    n_checks++;
    if (rsp_vec !== {4'b1001, 32'd0}) begin
      n_fail++;
      $display("FAIL divzero_err_rsp: got %h want %h", rsp_vec, {4'b1001, 32'd0});
    end
`else
    n_checks++;
    if ({busy, rsp_valid, alu_fun, alu_b} !== {2'b10, 4'b0011, 16'd0}) begin
      n_fail++;
      $display("FAIL divzero_issue: got %h want %h", {busy, rsp_valid, alu_fun, alu_b}, {2'b10, 4'b0011, 16'd0});
    end
    step();
    n_checks++;
    if (rsp_vec !== {4'b1000, 32'hFFFFFFFF}) begin
      n_fail++;
      $display("FAIL divzero_alu_rsp: got %h want %h", rsp_vec, {4'b1000, 32'hFFFFFFFF});
    end
`endif
    step();
    n_checks++;
    if ({rsp_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL divzero_done: got %b want 00", {rsp_valid, busy});
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_backpressure();
    test_sweep();
    test_carry();
    test_reset_midop();
    test_divzero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_scheduler.md
Name: alu_op_scheduler

Overview:
- Shares one 16-bit ALU_TOP instance between two requesters (req0, req1) through a valid/ready command interface and a valid/ready response interface.
- Performs round-robin arbitration and holds the ALU operands and function stable for the ALU latency.
- Selects the result group (arith/logic/cmp/shift) from the function code and returns a tagged 32-bit response.
- Sits directly above ALU_TOP; its ALU-side ports connect one-to-one to ALU_TOP's A, B, ALU_FUN and output groups.

Parameters:
- OPERAND_SIZE, 16, operand width of A/B.
- ALU_OUT, 32, ALU result width.
- ALU_LAT, 1, clock cycles from ALU_FUN/A/B stable to valid ALU outputs (range 1..7).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-low reset.
- reqN_valid  in  1  command valid, N = 0, 1.
- reqN_ready  out  1  command accepted this cycle.
- reqN_a, reqN_b  in  OPERAND_SIZE  operands.
- reqN_fun  in  4  ALU function code.
- alu_a, alu_b  out  OPERAND_SIZE  to ALU_TOP A/B.
- alu_fun  out  4  to ALU_TOP ALU_FUN.
- arith_out, logic_out, cmp_out, shift_out  in  ALU_OUT  ALU_TOP result groups.
- arith_flag, carry_out, logic_flag, cmp_flag, shift_flag  in  1  ALU_TOP flags.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed.
- rsp_id  out  1  requester that issued the operation.
- rsp_data  out  ALU_OUT  selected result.
- rsp_carry  out  1  carry_out when fun[3:2] = 00, else 0.
- rsp_err  out  1  divide-by-zero error; constant 0 unless ALU_SCHED_DIVZERO_EN is defined.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (RST=0, asynchronous):
  - State = IDLE.
  - alu_a, alu_b, alu_fun, rsp_data, rsp_id, rsp_carry, rsp_err, rsp_valid all 0.
  - Round-robin pointer last_grant = 1, so req0 wins the first contention.
  - Reset mid-operation aborts the operation silently; no response is produced.
- FSM states: IDLE -> WAIT -> RESP -> IDLE.
- IDLE:
  - grant = the only valid requester; if both are valid, grant the one opposite last_grant.
  - reqN_ready = (state == IDLE) && grant == N. This is combinational; at most one ready is high.
  - On valid && ready: register A/B/fun into alu_a/alu_b/alu_fun, update last_grant, store rsp_id, load wait counter with ALU_LAT-1, go to WAIT.
- WAIT:
  - alu_* held constant.
  - When the counter reaches 0: capture the result group selected by alu_fun[3:2] into rsp_data (00 arith_out, 01 logic_out, 10 cmp_out, 11 shift_out).
  - Capture rsp_carry per the rule above, then go to RESP.
  - Capture occurs at the edge ALU_LAT cycles after the issue edge.
- RESP:
  - rsp_valid = 1. rsp_* stable until rsp_valid && rsp_ready.
  - Then go to IDLE, with rsp_valid low the next cycle.
  - With rsp_ready held high, one operation completes every ALU_LAT+2 cycles.
- alu_a/alu_b/alu_fun keep the last issued values in IDLE; they are not cleared.
- A requester dropping valid before it is granted is legal; nothing is recorded.
- Changing reqN_* while valid is high and not yet granted is legal; the values sampled at the accept edge are used.
- rsp_ready high outside RESP is ignored.

Optional Feature:
- Macro: ALU_SCHED_DIVZERO_EN.
- Defined:
  - An accepted command with fun = 4'b0011 and b = 0 does not drive the ALU (alu_* unchanged).
  - The block goes directly to RESP the next cycle with rsp_data = 0, rsp_err = 1, rsp_carry = 0.
  - last_grant and rsp_id update normally.
- Not defined: the command is issued to the ALU like any other; rsp_err is tied to 0.

Decomposition:
- Shared package alu_pkg holds:
  - OPERAND_SIZE and ALU_OUT defaults.
  - Function-code constants (ADD=0000 ... SHR_B=1110, SHL_B=1111).
  - Group-select constants (GRP_ARITH=2'b00, GRP_LOGIC=2'b01, GRP_CMP=2'b10, GRP_SHIFT=2'b11).
  - FSM state encoding.
- One natural sub-module: rr_arbiter2. It is a two-input round-robin arbiter with the last_grant register, taking valids and an update strobe and producing a one-hot grant.

Test Plan:
- Single req0 (a=128, b=8, fun=0000), rsp_ready=1 -> req0_ready for 1 cycle; rsp_valid ALU_LAT+1 cycles later with rsp_data=136, rsp_id=0, rsp_carry=0.
- req0 and req1 valid together, both held (req0 fun=0010 MUL, req1 fun=1010 CMP>, a=128, b=8) -> req0 granted first with rsp 1024; then req1 with rsp 2, rsp_id=1; a third contention grants req0.
- req1 SHR_A (1100, a=128) with rsp_ready low for 5 cycles -> rsp_valid stays 1 with rsp_data=64 stable; no new ready until handshake; returns to IDLE after rsp_ready rises.
- Sweep all 16 fun codes with a=128, b=8 -> rsp_data = 136, 120, 1024, 16, 0, 136, 0xFFFFFFFF, 0xFFFFFF77, 0, 0, 2, 0, 64, 256, 4, 16.
- Assert RST=0 during WAIT -> all outputs 0 immediately, busy=0, no response after release; next request served correctly.
- With ALU_SCHED_DIVZERO_EN defined, DIV with a=128, b=0 -> rsp_err=1, rsp_data=0 one cycle after accept, alu_fun unchanged; without the macro the command reaches the ALU and rsp_err=0.
